// File: rtl/issuequeue_ooo.sv
// Out-of-order issue queue: entries wait for their sources to be written back,
// and the oldest ready entry (tracked by an age matrix) is moved into a single
// output register feeding one execute pipe. A redirect flush removes only the
// entries younger than the redirecting robidx.
module issuequeue_ooo #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 128,
  parameter int WB_PORTS  = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enq_valid,
  output logic                          enq_ready,
  input  logic [PREG_W-1:0]             enq_prs1,
  input  logic [PREG_W-1:0]             enq_prs2,
  input  logic                          enq_src1_is_reg,
  input  logic                          enq_src2_is_reg,
  input  logic                          enq_src1_state,
  input  logic                          enq_src2_state,
  input  logic                          enq_robidx_flag,
  input  logic [ROB_W-1:0]              enq_robidx,
  input  logic [PAYLOAD_W-1:0]          enq_payload,
  output logic                          deq_valid,
  input  logic                          deq_ready,
  output logic [PREG_W-1:0]             deq_prs1,
  output logic [PREG_W-1:0]             deq_prs2,
  output logic                          deq_robidx_flag,
  output logic [ROB_W-1:0]              deq_robidx,
  output logic [PAYLOAD_W-1:0]          deq_payload,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS-1:0]           wb_need_to_wb,
  input  logic [WB_PORTS*PREG_W-1:0]    wb_prd,
  input  logic                          flush_valid,
  input  logic                          flush_robidx_flag,
  input  logic [ROB_W-1:0]              flush_robidx,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  // Entry state. r_age[i][j] = 1 means entry i is older than entry j.
  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_busy1;
  logic [DEPTH-1:0]     r_busy2;
  logic [DEPTH-1:0]     r_age [DEPTH];
  logic [DEPTH-1:0]     r_flag;
  logic [PREG_W-1:0]    r_prs1 [DEPTH];
  logic [PREG_W-1:0]    r_prs2 [DEPTH];
  logic [ROB_W-1:0]     r_rob [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];

  // Output register
  logic                 r_deq_valid;
  logic [PREG_W-1:0]    r_deq_prs1;
  logic [PREG_W-1:0]    r_deq_prs2;
  logic                 r_deq_flag;
  logic [ROB_W-1:0]     r_deq_rob;
  logic [PAYLOAD_W-1:0] r_deq_payload;

  logic [WB_PORTS-1:0]  w_wake;
  logic [DEPTH-1:0]     w_clr1, w_clr2;
  logic                 w_enq_hit1, w_enq_hit2;
  logic                 w_enq_busy1, w_enq_busy2;
  logic [DEPTH-1:0]     w_kill, w_ready, w_sel;
  logic [DEPTH-1:0]     w_issue_oh, w_free_oh;
  logic [IDX_W-1:0]     w_sel_idx, w_free_idx;
  logic [CNT_W-1:0]     w_count;
  logic                 w_enq_fire, w_issue, w_deq_kill;

  // younger = wrap flags differ XOR flush index below entry index
  function automatic logic f_younger(input logic fflag, input logic [ROB_W-1:0] frob,
                                     input logic eflag, input logic [ROB_W-1:0] erob);
    return (fflag ^ eflag) ^ (frob < erob);
  endfunction

  assign w_wake = wb_valid & wb_need_to_wb;

  // Match writeback tags against stored sources and against the enqueuing sources
  always_comb begin
    w_clr1     = '0;
    w_clr2     = '0;
    w_enq_hit1 = 1'b0;
    w_enq_hit2 = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (w_wake[k]) begin
        if (wb_prd[k*PREG_W +: PREG_W] == enq_prs1) w_enq_hit1 = 1'b1;
        if (wb_prd[k*PREG_W +: PREG_W] == enq_prs2) w_enq_hit2 = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          if (wb_prd[k*PREG_W +: PREG_W] == r_prs1[i]) w_clr1[i] = 1'b1;
          if (wb_prd[k*PREG_W +: PREG_W] == r_prs2[i]) w_clr2[i] = 1'b1;
        end
      end
    end
  end

  assign w_enq_busy1 = enq_src1_state & enq_src1_is_reg & ~w_enq_hit1;
  assign w_enq_busy2 = enq_src2_state & enq_src2_is_reg & ~w_enq_hit2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic w_blocked;
      assign w_kill[gi]  = flush_valid & r_valid[gi] &
                           f_younger(flush_robidx_flag, flush_robidx, r_flag[gi], r_rob[gi]);
      assign w_ready[gi] = r_valid[gi] & ~r_busy1[gi] & ~r_busy2[gi] & ~w_kill[gi];
      // An entry loses select when some other ready entry is older than it
      always_comb begin
        w_blocked = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != gi && w_ready[j] && r_age[j][gi]) w_blocked = 1'b1;
        end
      end
      assign w_sel[gi] = w_ready[gi] & ~w_blocked;
    end
  endgenerate

  // Encode the one-hot oldest-ready vector into an index
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) w_sel_idx = IDX_W'(i);
    end
  end

  // Lowest-index free entry (scan downward so the lowest wins)
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  // Occupancy as popcount of the valid vector
  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CNT_W'(r_valid[i]);
    end
  end

  assign count      = w_count;
  assign enq_ready  = (w_count < CNT_W'(DEPTH)) & ~flush_valid;
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_issue    = (|w_ready) & (~r_deq_valid | deq_ready);
  assign w_issue_oh = w_issue ? w_sel : '0;
  assign w_free_oh  = w_enq_fire ? (DEPTH'(1) << w_free_idx) : '0;
  assign w_deq_kill = flush_valid & r_deq_valid &
                      f_younger(flush_robidx_flag, flush_robidx, r_deq_flag, r_deq_rob);

  // Control state: valids, busy bits, age matrix and output-valid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= '0;
      r_busy1     <= '0;
      r_busy2     <= '0;
      r_deq_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else begin
      r_valid <= (r_valid & ~w_kill & ~w_issue_oh) | w_free_oh;
      r_busy1 <= (r_busy1 & ~w_clr1 & ~w_free_oh) | (w_free_oh & {DEPTH{w_enq_busy1}});
      r_busy2 <= (r_busy2 & ~w_clr2 & ~w_free_oh) | (w_free_oh & {DEPTH{w_enq_busy2}});
      if (w_enq_fire) begin
        // every currently valid entry becomes older than the new one
        for (int i = 0; i < DEPTH; i++) r_age[i][w_free_idx] <= r_valid[i];
        r_age[w_free_idx] <= '0;
      end
      if (w_issue)
        r_deq_valid <= 1'b1;
      else if (w_deq_kill || deq_ready)
        r_deq_valid <= 1'b0;
    end
  end

  // Entry payload storage and output data register (no reset needed)
  always_ff @(posedge clock) begin
    if (w_enq_fire) begin
      r_prs1[w_free_idx]    <= enq_prs1;
      r_prs2[w_free_idx]    <= enq_prs2;
      r_flag[w_free_idx]    <= enq_robidx_flag;
      r_rob[w_free_idx]     <= enq_robidx;
      r_payload[w_free_idx] <= enq_payload;
    end
    if (w_issue) begin
      r_deq_prs1    <= r_prs1[w_sel_idx];
      r_deq_prs2    <= r_prs2[w_sel_idx];
      r_deq_flag    <= r_flag[w_sel_idx];
      r_deq_rob     <= r_rob[w_sel_idx];
      r_deq_payload <= r_payload[w_sel_idx];
    end
  end

  assign deq_valid       = r_deq_valid;
  assign deq_prs1        = r_deq_prs1;
  assign deq_prs2        = r_deq_prs2;
  assign deq_robidx_flag = r_deq_flag;
  assign deq_robidx      = r_deq_rob;
  assign deq_payload     = r_deq_payload;

endmodule
